instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the CPU's decode input.
- Drives the synchronous instruction memory (1-cycle read latency) and tracks in-flight reads.
- Buffers returned words with their PCs in a DEPTH-entry prefetch FIFO and hands them to decode over a valid/ready handshake.
- On a PC redirect it flushes the FIFO, discards stale memory responses and restarts fetch at the target.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2).
- ADDR_W, 7, instruction word-address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  level; suppresses new fetch issue.
- imem_addr  out  ADDR_W  instruction memory address (registered).
- imem_rd_en  out  1  read issued this cycle (registered).
- imem_q  in  DATA_W  memory data, valid the cycle after an issue.
- instr_out  out  DATA_W  head-of-FIFO instruction.
- instr_pc  out  ADDR_W  PC of instr_out.
- instr_valid  out  1  instr_out/instr_pc valid.
- instr_ready  in  1  decode accepts head this cycle.
- empty  out  1  FIFO count == 0.
- full  out  1  FIFO count == DEPTH.

Behaviour:
- Reset values:
  - imem_addr = RESET_PC; imem_rd_en = 0; instr_valid = 0; instr_out = 0; instr_pc = 0; empty = 1; full = 0.
  - FIFO count = 0; pending = 0; state = S_IDLE.
- FSM states:
  - S_IDLE: one cycle after reset; no issue. Next state is S_RUN, or S_HALT if halt = 1.
  - S_RUN: issue allowed. Go to S_HALT when halt = 1.
  - S_HALT: no issue; pending response still captured; FIFO still drains. Return to S_RUN when halt = 0.
- Issue rule:
  - Registered imem_rd_en = 1 for the next cycle iff state is S_RUN, halt = 0, redirect_valid = 0, and count + pending + (1 if imem_rd_en = 1 now) < DEPTH.
  - The current cycle's pop is not credited.
  - When an issue is registered, imem_addr advances by 1 mod 2^ADDR_W (0x7F wraps to 0x00).
- pending = registered copy of imem_rd_en (read in flight).
  - When pending = 1 and no redirect: {imem_q, address of that read} is pushed into the FIFO at the edge.
- Pop: the head is removed when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (cycle N, redirect_valid = 1):
  - FIFO flushed; pending cleared, so the N+1 response is dropped.
  - imem_addr = redirect_pc and imem_rd_en = 1 in N+1 (subject to halt).
  - Data returns in N+2; instr_valid = 1 in N+3.
  - Redirect overrides a same-cycle pop and push: the popped word is considered consumed, nothing is pushed, and instr_valid = 0 in N+1.
  - Redirect is honoured in S_HALT (address loaded, no issue until halt drops) and in S_IDLE.
- Reset mid-operation: all state returns to reset values; any in-flight response is ignored.
- Latency after reset release: first issue in cycle 1; first instr_valid in cycle 3.
- Steady-state throughput with instr_ready = 1: one instruction per cycle.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the FIFO is empty and a valid response arrives, it is presented combinationally on instr_out/instr_pc with instr_valid = 1 that same cycle.
  - If accepted, it is not written.
  - Redirect→valid latency is 2 cycles; reset→first valid is 2 cycles.
- Undefined: all responses pass through FIFO storage, with the latencies given above.

Test Plan:
- Reset, RESET_PC = 0, mem[k] = 0xE0000000+k, instr_ready = 1 → instr_valid first in cycle 3; instr_pc 0,1,2,3… one per cycle; instr_out = 0xE0000000+pc.
- instr_ready = 0 from cycle 0 → full = 1, count = 4, imem_rd_en = 0 with no further address change; ready raised → pcs 0,1,2,3,4 delivered with no gap or duplicate.
- Redirect to 0x40 with a read pending → the stale word is never output; next instr_pc = 0x40 at N+3, then 0x41.
- Redirect to 0x7E → instr_pc sequence 0x7E, 0x7F, 0x00, 0x01.
- Redirect in the same cycle as pop, with halt = 1 for 5 cycles → instr_valid = 0 in N+1; no imem_rd_en while halted; fetch resumes at the target one cycle after halt drops.
- FETCH_BYPASS_EN defined, empty FIFO, redirect to 0x10 → instr_valid with instr_pc = 0x10 at N+2.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage driving imem and feeding decode via a prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [DATA_W-1:0] imem_q,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              empty,
  output logic              full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [PW+1:0] LIMIT = (PW+2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] ppc_q;
  logic rd_en_q, rd_en_d;
  logic pend_q, pend_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [PW+1:0] inflight;
  logic room, has, byp;
  logic push, pop, pop_f;

  // Slots already claimed: stored words, the response arriving now,
  // and the read issued now. A pop this cycle is not credited.
  assign inflight = (PW+2)'(cnt_q)
                  + (PW+2)'(pend_q)
                  + (PW+2)'(rd_en_q);
  assign room = inflight < LIMIT;
  assign has  = cnt_q != '0;

`ifdef FETCH_BYPASS_EN
  assign byp = pend_q && !has;
`else
  assign byp = 1'b0;
`endif

  assign instr_valid = has || byp;
  assign instr_out   = has ? dat_q[rp_q]
                     : (byp ? imem_q : '0);
  assign instr_pc    = has ? pcs_q[rp_q]
                     : (byp ? ppc_q : '0);
  assign pop   = instr_valid && instr_ready;
  assign pop_f = pop && has;
  assign push  = pend_q && !redirect_valid
              && !(byp && instr_ready);
  assign empty = !has;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign imem_addr  = addr_q;
  assign imem_rd_en = rd_en_q;

  // Next-state logic for the fetch control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = halt ? S_HALT : S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue decision and fetch address; a redirect always loads the target.
  always_comb begin
    addr_d  = addr_q;
    npc_d   = npc_q;
    rd_en_d = 1'b0;
    pend_d  = rd_en_q && !redirect_valid;
    if (redirect_valid) begin
      addr_d = redirect_pc;
      npc_d  = redirect_pc;
      if (state_d == S_RUN) begin
        rd_en_d = 1'b1;
        npc_d   = redirect_pc + ADDR_W'(1);
      end
    end else if (state_d == S_RUN && room) begin
      rd_en_d = 1'b1;
      addr_d  = npc_q;
      npc_d   = npc_q + ADDR_W'(1);
    end
  end

  // FIFO pointer/count update; a redirect flushes everything.
  always_comb begin
    cnt_d = cnt_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    if (redirect_valid) begin
      cnt_d = '0;
      rp_d  = '0;
      wp_d  = '0;
    end else begin
      if (push)  wp_d = wp_q + PW'(1);
      if (pop_f) rp_d = rp_q + PW'(1);
      unique case ({push, pop_f})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= RST_PC;
      npc_q   <= RST_PC;
      ppc_q   <= '0;
      rd_en_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      npc_q   <= npc_d;
      ppc_q   <= addr_q;
      rd_en_q <= rd_en_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
    end
  end

  // FIFO storage: response word with the address it was read from.
  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wp_q] <= imem_q;
      pcs_q[wp_q] <= ppc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of instr_fetch_unit.
// Delivered words must form a contiguous pc stream from reset or redirect target.
module tb_instr_fetch_unit;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [6:0]  redirect_pc;
  logic        halt;
  logic [6:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_q;
  logic [31:0] instr_out;
  logic [6:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        empty;
  logic        full;

  int vec;
  int errs;
  int cyc;
  logic [6:0] exp_pc;

  instr_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imem_addr(imem_addr),
    .imem_rd_en(imem_rd_en),
    .imem_q(imem_q),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .empty(empty),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memv(input logic [6:0] a);
    return 32'hE000_0000 + {25'd0, a};
  endfunction

  // 1-cycle synchronous memory; junk on the bus when no read.
  always @(posedge clk)
    imem_q <= imem_rd_en ? memv(imem_addr) : $urandom();

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Finish the current cycle; every accepted word is checked
  // against the expected pc stream.
  task automatic step();
    @(negedge clk);
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      chk("stream_pc", 64'(instr_pc), 64'(exp_pc));
      chk("stream_data", 64'(instr_out), 64'(memv(exp_pc)));
      exp_pc = exp_pc + 7'd1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    exp_pc = 7'd0;
  endtask

  task automatic chk_reset();
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_rd_en", 64'(imem_rd_en), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_out", 64'(instr_out), 64'd0);
    chk("rst_pc", 64'(instr_pc), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
  endtask

  // Redirect with ready=1, halt=0: gap then target, target+1, ...
  task automatic redir(input logic [6:0] tgt);
    logic [6:0] e;
    chk("pre_rd_en", 64'(imem_rd_en), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    step();
    redirect_valid = 1'b0;
    exp_pc = tgt;
    chk("rd_n1_rd_en", 64'(imem_rd_en), 64'd1);
    chk("rd_n1_addr", 64'(imem_addr), 64'(tgt));
    for (int k = 1; k < LAT; k++) begin
      chk("rd_gap_valid", 64'(instr_valid), 64'd0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      e = tgt + 7'(k);
      chk("rd_valid", 64'(instr_valid), 64'd1);
      chk("rd_seq_pc", 64'(instr_pc), 64'(e));
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec = 0;
    errs = 0;
    cyc = 0;
    exp_pc = 7'd0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 7'd0;
    halt = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset and streaming with decode always ready.
    do_reset();
    chk_reset();
    for (int i = 0; i < 12; i++) begin
      if (cyc >= 1) begin
        chk("t1_rd_en", 64'(imem_rd_en), 64'd1);
        chk("t1_addr", 64'(imem_addr), 64'(cyc - 1));
      end
      chk("t1_valid", 64'(instr_valid), 64'(cyc >= LAT));
      step();
    end

    // Decode stalled from cycle 0: fill, stop issuing, then drain.
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (cyc >= 1 && cyc <= 4)
        chk("t2_rd_on", 64'(imem_rd_en), 64'd1);
      if (cyc >= 5)
        chk("t2_rd_off", 64'(imem_rd_en), 64'd0);
      if (cyc == 5)
        chk("t2_not_full", 64'(full), 64'd0);
      if (cyc >= 6) begin
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_empty", 64'(empty), 64'd0);
        chk("t2_head", 64'(instr_pc), 64'd0);
      end
      step();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("t2_drain_valid", 64'(instr_valid), 64'd1);
      step();
    end

    // Redirects with a read in flight, including address wrap.
    redir(7'h40);
    redir(7'h7E);

    // Redirect colliding with a pop while halted for 5 cycles.
    chk("t5_pop_valid", 64'(instr_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 7'h20;
    halt = 1'b1;
    step();
    redirect_valid = 1'b0;
    exp_pc = 7'h20;
    for (int k = 1; k <= 5; k++) begin
      chk("t5_rd_off", 64'(imem_rd_en), 64'd0);
      if (k == 1) begin
        chk("t5_n1_valid", 64'(instr_valid), 64'd0);
        chk("t5_n1_addr", 64'(imem_addr), 64'h20);
      end
      if (k == 5) halt = 1'b0;
      step();
    end
    chk("t5_resume_rd", 64'(imem_rd_en), 64'd1);
    chk("t5_resume_addr", 64'(imem_addr), 64'h20);
    step();
    for (int k = 0; k < LAT - 2; k++) begin
      chk("t5_gap_valid", 64'(instr_valid), 64'd0);
      step();
    end
    chk("t5_valid", 64'(instr_valid), 64'd1);
    chk("t5_pc", 64'(instr_pc), 64'h20);
    step();
    step();

    // Reset in the middle of streaming.
    do_reset();
    chk_reset();
    for (int i = 0; i < LAT + 3; i++) begin
      chk("t6_valid", 64'(instr_valid), 64'(cyc >= LAT));
      step();
    end

    // Random ready/halt/redirect traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 7'($urandom());
      end else begin
        redirect_valid = 1'b0;
      end
`ifndef FETCH_BYPASS_EN
      chk("rnd_empty", 64'(empty), 64'(!instr_valid));
`endif
      step();
      if (redirect_valid) exp_pc = redirect_pc;
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 10 && instr_valid !== 1'b1; k++)
      step();
    chk("rnd_live", 64'(instr_valid), 64'd1);
    for (int k = 0; k < 8; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
